writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
// Final pipeline stage, directly downstream of the memory stage; consumes its registered outputs.
// Aligns and extends load data, drives the register-file write port, owns the machine-mode CSR file
// (trap and mret handling, cycle/instret counters) and the WFI sleep state.
// Redirects fetch and flushes upstream stages on trap entry or mret.
// PARAMETERS
// MTVEC_RESET  32'h0000_0000  reset value of mtvec; only direct mode is supported
// PORTS
// clk               in   1   clock, all state on posedge
// reset             in   1   asynchronous, active-high
// pc_in             in   32  pc of the instruction in WB
// next_pc_in        in   32  pc+4, or the link value
// alu_data_in       in   32  ALU result; memory address for loads; old CSR value for CSR ops
// csr_data_in       in   32  new CSR value for CSR ops
// load_data_in      in   32  raw aligned word from the memory stage
// load_store_size_in in  2   00 byte, 01 half, 10 word
// load_signed_in    in   1   sign-extend the load result
// write_select_in   in   2   00 alu, 01 load, 10 next_pc, 11 alu plus CSR write
// rd_addr_in        in   6   bits [4:0] select the destination register; bit 5 is ignored
// csr_addr_in       in   12  CSR written when write_select_in=11
// mret_in, wfi_in   in   1   instruction is MRET / WFI
// valid_in          in   1   WB holds a real instruction
// exception_in      in   1   instruction faulted upstream
// ecause_in         in   4   exception cause code
// irq_external, irq_timer  in  1  level interrupt lines, mirrored into mip.MEIP / mip.MTIP
// csr_read_addr     in   12  combinational CSR read port for decode
// csr_read_data     out  32  old (pre-edge) value; 0 for unimplemented addresses
// rf_write_en       out  1   register-file write strobe
// rf_write_addr     out  5   register-file write address
// rf_write_data     out  32  register-file write data
// redirect_out      out  1   fetch must jump; upstream stages must invalidate
// redirect_address  out  32  target of the redirect
// stall_out         out  1   high while sleeping in WFI
// BEHAVIOUR
// - Outputs are combinational from the inputs and state. All are 0 when valid_in=0 or reset=1.
// - retire = valid_in & !stall_out & !exception_in & !irq_take.
// - irq_take = valid_in & !stall_out & mstatus.MIE & |(mie & mip).
// - Priority: exception_in > irq_take > mret_in > normal retire.
// - Exception: mepc<=pc_in; mcause<={28'b0, ecause_in}; MPIE<=MIE; MIE<=0; redirect to {mtvec[31:2], 2'b00}.
// - Interrupt: same update as exception with mepc<=pc_in, so the instruction is not retired.
//   mcause is 32'h8000_000B for external, 32'h8000_0007 for timer; external wins if both are pending.
// - MRET (when retiring): MIE<=MPIE; MPIE<=1; redirect to mepc.
// - rf_write_en = retire & (rd_addr_in[4:0]!=0).
// - Load result: word = load_data_in >> {alu_data_in[1:0], 3'b0}.
//   Size 00 takes [7:0] and size 01 takes [15:0]; both are zero- or sign-extended per load_signed_in.
// - CSR write on retire with write_select_in=11; a trap in the same cycle suppresses it.
// - Implemented CSRs: mstatus 300 (MIE bit 3, MPIE bit 7 only), mie 304 (bits 11, 7), mtvec 305,
//   mscratch 340, mepc 341 (bits [1:0] forced to 0), mcause 342, mip 344 (read-only).
//   Counters, writable: mcycle B00/B80, minstret B02/B82.
//   Read-only aliases: C00/C80, C02/C82.
//   Writes to any other address are ignored.
// - mcycle increments every cycle. minstret increments on retire. A CSR write to a counter half
//   beats that half's increment in the same cycle. Carries propagate from the low half to the high half.
// - FSM RUN/SLEEP. RUN->SLEEP when a WFI retires. SLEEP->RUN when |(mie & mip), regardless of MIE.
//   stall_out = (state==SLEEP) & !|(mie & mip).
// - Reset values: mstatus=0, mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0,
//   counters=0, state=RUN.
// - Reset asserted mid-SLEEP returns the FSM to RUN and clears all CSRs immediately.
// TESTING
// - LB, addr 0x...3, load_data 0x80AB_CDEF, signed, rd=5 -> rf_write_data=0xFFFF_FF80, en=1.
// - LHU, addr 0x...2, load_data 0x8001_1234 -> 0x0000_8001. rd=0 -> rf_write_en=0.
// - mtvec=0x200, MIE=1, exception_in with ecause 2 at pc 0x100 -> redirect to 0x200;
//   mepc=0x100, mcause=2, MIE=0, MPIE=1, no register write, minstret unchanged.
// - Then MRET -> redirect to 0x100, MIE=1.
// - Exception and pending enabled external IRQ in the same cycle -> mcause=2, not 0x8000_000B.
// - WFI retires with mie=0x800 and no IRQ -> stall_out=1 for 5 cycles.
//   Raise irq_external -> stall_out=0 that cycle; the next valid instruction traps
//   with mcause 0x8000_000B when MIE=1.
// - Reset pulse while sleeping -> stall_out=0, mtvec=MTVEC_RESET, mcycle restarts from 0.

Source files
------------

// File: rtl/writeback_if.sv
// ---------------------------------------------------------------------------
// writeback_if
// Bundle between the memory stage and the writeback stage, plus the
// writeback-stage outputs (register-file write port, fetch redirect, stall,
// and the decode-side CSR read port).
//   master : memory-stage side; drives instruction fields and IRQ lines,
//            receives the writeback results.
//   slave  : the writeback stage itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface writeback_if;
  // Instruction held in WB
  logic [31:0] pc_in;
  logic [31:0] next_pc_in;
  logic [31:0] alu_data_in;
  logic [31:0] csr_data_in;
  logic [31:0] load_data_in;
  logic [1:0]  load_store_size_in;
  logic        load_signed_in;
  logic [1:0]  write_select_in;
  logic [5:0]  rd_addr_in;
  logic [11:0] csr_addr_in;
  logic        mret_in;
  logic        wfi_in;
  logic        valid_in;
  logic        exception_in;
  logic [3:0]  ecause_in;
  // Level interrupt lines
  logic        irq_external;
  logic        irq_timer;
  // Decode-side CSR read port
  logic [11:0] csr_read_addr;
  logic [31:0] csr_read_data;
  // Writeback results
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        redirect_out;
  logic [31:0] redirect_address;
  logic        stall_out;

  modport master (
    output pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in,
           load_store_size_in, load_signed_in, write_select_in, rd_addr_in,
           csr_addr_in, mret_in, wfi_in, valid_in, exception_in, ecause_in,
           irq_external, irq_timer, csr_read_addr,
    input  csr_read_data, rf_write_en, rf_write_addr, rf_write_data,
           redirect_out, redirect_address, stall_out
  );

  modport slave (
    input  pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in,
           load_store_size_in, load_signed_in, write_select_in, rd_addr_in,
           csr_addr_in, mret_in, wfi_in, valid_in, exception_in, ecause_in,
           irq_external, irq_timer, csr_read_addr,
    output csr_read_data, rf_write_en, rf_write_addr, rf_write_data,
           redirect_out, redirect_address, stall_out
  );
endinterface

// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
// Final pipeline stage. Aligns and extends load data, drives the register-file
// write port, owns the machine-mode CSR file (trap entry, mret, mcycle and
// minstret) and the WFI sleep state, and redirects fetch on trap or mret.
// Ports:
//   clk    : clock, all state updates on posedge
//   reset  : asynchronous, active-high
//   wb     : writeback_if.slave bundle (instruction fields, IRQ lines,
//            CSR read port, register-file write, redirect, stall)
// All bundle outputs are combinational and forced to 0 while reset is high
// or no valid instruction sits in WB.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module writeback #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  writeback_if.slave wb
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [1:0] WS_ALU  = 2'b00;
  localparam logic [1:0] WS_LOAD = 2'b01;
  localparam logic [1:0] WS_LINK = 2'b10;
  localparam logic [1:0] WS_CSR  = 2'b11;

  typedef enum logic {ST_RUN, ST_SLEEP} state_t;

  state_t      r_state, w_state_next;

  // CSR state
  logic        r_mstatus_mie, r_mstatus_mpie;
  logic        r_mie_meie, r_mie_mtie;
  logic [31:2] r_mtvec;        // direct mode only, low bits read as 0
  logic [31:0] r_mscratch;
  logic [31:2] r_mepc;         // instruction-aligned, low bits read as 0
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle, r_minstret;

  // Control
  logic [31:0] w_mip, w_mie, w_mstatus;
  logic        w_irq_pending, w_stall, w_active;
  logic        w_exc, w_irq_take, w_trap, w_retire, w_mret, w_csr_we;
  logic [31:0] w_trap_cause;
  logic [31:0] w_load_word, w_load_result, w_wdata;
  logic [31:0] w_csr_rdata;
  logic [63:0] w_mcycle_inc, w_minstret_inc;
  logic [63:0] w_mcycle_next, w_minstret_next;
  logic        w_unused;

  assign w_unused = wb.rd_addr_in[5];

  assign w_mip     = {20'b0, wb.irq_external, 3'b0, wb.irq_timer, 7'b0};
  assign w_mie     = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
  assign w_mstatus = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  // Wake-up ignores mstatus.MIE; only the interrupt take depends on it.
  assign w_irq_pending = |(w_mie & w_mip);
  assign w_stall       = (r_state == ST_SLEEP) && !w_irq_pending;
  assign w_active      = wb.valid_in && !w_stall;

  assign w_exc      = w_active && wb.exception_in;
  assign w_irq_take = w_active && r_mstatus_mie && w_irq_pending;
  assign w_trap     = w_exc || w_irq_take;
  assign w_retire   = w_active && !wb.exception_in && !w_irq_take;
  assign w_mret     = w_retire && wb.mret_in;
  assign w_csr_we   = w_retire && (wb.write_select_in == WS_CSR);

  // Upstream exception outranks any interrupt; external outranks timer.
  always_comb begin
    if (wb.exception_in)                    w_trap_cause = {28'b0, wb.ecause_in};
    else if (wb.irq_external && r_mie_meie) w_trap_cause = 32'h8000_000B;
    else                                    w_trap_cause = 32'h8000_0007;
  end

  // Load alignment and extension
  assign w_load_word = wb.load_data_in >> {wb.alu_data_in[1:0], 3'b000};

  // NOTE: every variable driven in always_comb gets a default before any
  // branch; a missed path would otherwise infer a latch.
  always_comb begin
    w_load_result = w_load_word;
    case (wb.load_store_size_in)
      2'b00:   w_load_result = {{24{wb.load_signed_in & w_load_word[7]}},  w_load_word[7:0]};
      2'b01:   w_load_result = {{16{wb.load_signed_in & w_load_word[15]}}, w_load_word[15:0]};
      default: w_load_result = w_load_word;
    endcase
  end

  // For CSR ops the ALU result already carries the old CSR value.
  always_comb begin
    w_wdata = wb.alu_data_in;
    case (wb.write_select_in)
      WS_LOAD: w_wdata = w_load_result;
      WS_LINK: w_wdata = wb.next_pc_in;
      default: w_wdata = wb.alu_data_in;
    endcase
  end

  // CSR read port (pre-edge values)
  always_comb begin
    w_csr_rdata = 32'b0;
    case (wb.csr_read_addr)
      CSR_MSTATUS:               w_csr_rdata = w_mstatus;
      CSR_MIE:                   w_csr_rdata = w_mie;
      CSR_MTVEC:                 w_csr_rdata = {r_mtvec, 2'b00};
      CSR_MSCRATCH:              w_csr_rdata = r_mscratch;
      CSR_MEPC:                  w_csr_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:                w_csr_rdata = r_mcause;
      CSR_MIP:                   w_csr_rdata = w_mip;
      CSR_MCYCLE,   CSR_CYCLE:   w_csr_rdata = r_mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  w_csr_rdata = r_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: w_csr_rdata = r_minstret[31:0];
      CSR_MINSTRH,  CSR_INSTRETH:w_csr_rdata = r_minstret[63:32];
      default:                   w_csr_rdata = 32'b0;
    endcase
  end

  // Counters: a write to one half replaces that half's increment. A low-half
  // write also suppresses the carry, since that increment never happened.
  assign w_mcycle_inc   = r_mcycle + 64'd1;
  assign w_minstret_inc = r_minstret + {63'b0, w_retire};

  always_comb begin
    w_mcycle_next   = w_mcycle_inc;
    w_minstret_next = w_minstret_inc;
    if (w_csr_we) begin
      case (wb.csr_addr_in)
        CSR_MCYCLE:   w_mcycle_next   = {r_mcycle[63:32], wb.csr_data_in};
        CSR_MCYCLEH:  w_mcycle_next   = {wb.csr_data_in, w_mcycle_inc[31:0]};
        CSR_MINSTRET: w_minstret_next = {r_minstret[63:32], wb.csr_data_in};
        CSR_MINSTRH:  w_minstret_next = {wb.csr_data_in, w_minstret_inc[31:0]};
        default: ;
      endcase
    end
  end

  // Sleep FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_retire && wb.wfi_in) w_state_next = ST_SLEEP;
      ST_SLEEP: if (w_irq_pending)         w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mtvec        <= MTVEC_RESET[31:2];
      r_mscratch     <= 32'b0;
      r_mepc         <= 30'b0;
      r_mcause       <= 32'b0;
      r_mcycle       <= 64'b0;
      r_minstret     <= 64'b0;
    end else begin
      r_mcycle   <= w_mcycle_next;
      r_minstret <= w_minstret_next;

      if (w_csr_we) begin
        case (wb.csr_addr_in)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= wb.csr_data_in[3];
            r_mstatus_mpie <= wb.csr_data_in[7];
          end
          CSR_MIE: begin
            r_mie_meie <= wb.csr_data_in[11];
            r_mie_mtie <= wb.csr_data_in[7];
          end
          CSR_MTVEC:    r_mtvec    <= wb.csr_data_in[31:2];
          CSR_MSCRATCH: r_mscratch <= wb.csr_data_in;
          CSR_MEPC:     r_mepc     <= wb.csr_data_in[31:2];
          CSR_MCAUSE:   r_mcause   <= wb.csr_data_in;
          default: ;
        endcase
      end

      // Trap and retire are mutually exclusive, so a trap never coexists
      // with a CSR write or an mret in the same cycle.
      if (w_trap) begin
        r_mepc         <= wb.pc_in[31:2];
        r_mcause       <= w_trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    wb.rf_write_en      = 1'b0;
    wb.rf_write_addr    = 5'b0;
    wb.rf_write_data    = 32'b0;
    wb.redirect_out     = 1'b0;
    wb.redirect_address = 32'b0;
    wb.stall_out        = 1'b0;
    wb.csr_read_data    = 32'b0;
    if (!reset && wb.valid_in) begin
      wb.rf_write_en   = w_retire && (wb.rd_addr_in[4:0] != 5'd0);
      wb.rf_write_addr = wb.rd_addr_in[4:0];
      wb.rf_write_data = w_wdata;
      wb.stall_out     = w_stall;
      wb.csr_read_data = w_csr_rdata;
      if (w_trap) begin
        wb.redirect_out     = 1'b1;
        wb.redirect_address = {r_mtvec, 2'b00};
      end else if (w_mret) begin
        wb.redirect_out     = 1'b1;
        wb.redirect_address = {r_mepc, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback
// Directed bench for the writeback stage. Inputs change just after each
// falling edge; combinational outputs are sampled 1 ns later, well away from
// the rising edge. The step index k equals mcycle at that step, since reset
// is released on a falling edge and each step is one clock apart.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_writeback;

  localparam logic [31:0] MTVEC_INIT = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  writeback_if bus ();

  writeback #(.MTVEC_RESET(MTVEC_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_read_addr = addr;
    #1;
    check(tag, bus.csr_read_data, exp);
  endtask

  // Valid no-op (ALU write to x0); IRQ lines are left untouched.
  task automatic nop();
    bus.pc_in              = 32'h0;
    bus.next_pc_in         = 32'h0;
    bus.alu_data_in        = 32'h0;
    bus.csr_data_in        = 32'h0;
    bus.load_data_in       = 32'h0;
    bus.load_store_size_in = 2'b10;
    bus.load_signed_in     = 1'b0;
    bus.write_select_in    = 2'b00;
    bus.rd_addr_in         = 6'd0;
    bus.csr_addr_in        = 12'h0;
    bus.mret_in            = 1'b0;
    bus.wfi_in             = 1'b0;
    bus.valid_in           = 1'b1;
    bus.exception_in       = 1'b0;
    bus.ecause_in          = 4'h0;
    bus.csr_read_addr      = 12'h0;
  endtask

  task automatic step();
    @(negedge clk);
    nop();
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.write_select_in = 2'b11;
    bus.csr_addr_in     = addr;
    bus.csr_data_in     = data;
  endtask

  initial begin
    reset            = 1'b1;
    bus.irq_external = 1'b0;
    bus.irq_timer    = 1'b0;
    nop();

    // Outputs held at 0 during reset even with a valid instruction
    @(negedge clk);
    nop();
    bus.rd_addr_in  = 6'd3;
    bus.alu_data_in = 32'h1234;
    #1;
    check("reset_rf_en",   32'(bus.rf_write_en), 32'h0);
    check("reset_rf_data", bus.rf_write_data, 32'h0);
    chk_csr("reset_csr_gated", 12'h305, 32'h0);

    // k0: release reset, reset-state CSRs
    step();
    reset = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("bubble_rf_en", 32'(bus.rf_write_en), 32'h0);
    bus.valid_in = 1'b1;
    chk_csr("rst_mcycle",  12'hB00, 32'h0);
    chk_csr("rst_mtvec",   12'h305, MTVEC_INIT);
    chk_csr("rst_mstatus", 12'h300, 32'h0);
    chk_csr("rst_minstret",12'hB02, 32'h0);
    chk_csr("rst_mip",     12'h344, 32'h0);                     // retire -> 1

    // k1: LB signed, byte 3 of 0x80ABCDEF
    step();
    bus.write_select_in = 2'b01; bus.load_store_size_in = 2'b00; bus.load_signed_in = 1'b1;
    bus.alu_data_in = 32'h0000_0003; bus.load_data_in = 32'h80AB_CDEF; bus.rd_addr_in = 6'd5;
    #1;
    check("lb_en",   32'(bus.rf_write_en),   32'h1);
    check("lb_addr", 32'(bus.rf_write_addr), 32'h5);
    check("lb_data", bus.rf_write_data,      32'hFFFF_FF80);
    chk_csr("k1_minstret", 12'hB02, 32'h1);
    chk_csr("k1_cycle",    12'hC00, 32'h1);                      // retire -> 2

    // k2: LHU upper half, rd=0
    step();
    bus.write_select_in = 2'b01; bus.load_store_size_in = 2'b01;
    bus.alu_data_in = 32'h0000_0402; bus.load_data_in = 32'h8001_1234; bus.rd_addr_in = 6'd0;
    #1;
    check("lhu_data", bus.rf_write_data, 32'h0000_8001);
    check("lhu_x0_en", 32'(bus.rf_write_en), 32'h0);             // retire -> 3

    // k3: link value, rd bit 5 ignored
    step();
    bus.write_select_in = 2'b10; bus.next_pc_in = 32'h104; bus.rd_addr_in = 6'h27;
    #1;
    check("link_data", bus.rf_write_data, 32'h104);
    check("link_addr", 32'(bus.rf_write_addr), 32'h7);            // retire -> 4

    // k4: mtvec <= 0x200, old value returned via ALU path
    step();
    csr_write(12'h305, 32'h200); bus.alu_data_in = MTVEC_INIT; bus.rd_addr_in = 6'd1;
    #1;
    check("csrw_rf_data", bus.rf_write_data, MTVEC_INIT);        // retire -> 5

    // k5: mstatus.MIE <= 1
    step();
    csr_write(12'h300, 32'h8);
    chk_csr("mtvec_written", 12'h305, 32'h200);                  // retire -> 6

    // k6: mie <= MEIE
    step();
    csr_write(12'h304, 32'h800);
    chk_csr("mstatus_mie", 12'h300, 32'h8);                       // retire -> 7

    // k7: exception, cause 2, at pc 0x100
    step();
    bus.pc_in = 32'h100; bus.exception_in = 1'b1; bus.ecause_in = 4'd2; bus.rd_addr_in = 6'd9;
    #1;
    check("exc_redirect", 32'(bus.redirect_out), 32'h1);
    check("exc_target",   bus.redirect_address,  32'h200);
    check("exc_rf_en",    32'(bus.rf_write_en),  32'h0);
    chk_csr("mie_read", 12'h304, 32'h800);

    // k8
    step();
    chk_csr("exc_mepc",     12'h341, 32'h100);
    chk_csr("exc_mcause",   12'h342, 32'h2);
    chk_csr("exc_mstatus",  12'h300, 32'h80);
    chk_csr("exc_minstret", 12'hB02, 32'h7);                     // retire -> 8

    // k9: MRET
    step();
    bus.mret_in = 1'b1;
    #1;
    check("mret_redirect", 32'(bus.redirect_out), 32'h1);
    check("mret_target",   bus.redirect_address,  32'h100);       // retire -> 9

    // k10
    step();
    chk_csr("mret_mstatus", 12'h300, 32'h88);                     // retire -> 10

    // k11: exception together with enabled pending external IRQ
    step();
    bus.irq_external = 1'b1;
    bus.pc_in = 32'h140; bus.exception_in = 1'b1; bus.ecause_in = 4'd2;
    #1;
    check("exc_irq_target", bus.redirect_address, 32'h200);

    // k12
    step();
    bus.irq_external = 1'b0;
    chk_csr("exc_beats_irq", 12'h342, 32'h2);                     // retire -> 11

    // k13: re-enable MIE
    step();
    csr_write(12'h300, 32'h8);                                    // retire -> 12

    // k14: WFI retires
    step();
    bus.wfi_in = 1'b1;
    #1;
    check("wfi_no_stall", 32'(bus.stall_out), 32'h0);            // retire -> 13

    // k15..k19: asleep
    for (int i = 0; i < 5; i++) begin
      step();
      bus.rd_addr_in = 6'd3;
      #1;
      check($sformatf("sleep_stall_%0d", i), 32'(bus.stall_out), 32'h1);
      check($sformatf("sleep_rf_en_%0d", i), 32'(bus.rf_write_en), 32'h0);
    end
    chk_csr("sleep_instret", 12'hC02, 32'd13);

    // k20: external IRQ wakes and is taken immediately
    step();
    bus.irq_external = 1'b1; bus.pc_in = 32'h180;
    #1;
    check("wake_stall",    32'(bus.stall_out),    32'h0);
    check("irq_redirect",  32'(bus.redirect_out), 32'h1);
    check("irq_target",    bus.redirect_address,  32'h200);

    // k21
    step();
    bus.irq_external = 1'b0;
    chk_csr("irq_mcause",   12'h342, 32'h8000_000B);
    chk_csr("irq_mepc",     12'h341, 32'h180);
    chk_csr("irq_mstatus",  12'h300, 32'h80);
    chk_csr("irq_minstret", 12'hB02, 32'd13);                    // retire -> 14

    // k22, k23: enable timer, MIE
    step();
    csr_write(12'h304, 32'h880);                                 // retire -> 15
    step();
    csr_write(12'h300, 32'h8);                                   // retire -> 16

    // k24: timer IRQ
    step();
    bus.irq_timer = 1'b1; bus.pc_in = 32'h1C0;
    #1;
    check("tirq_redirect", 32'(bus.redirect_out), 32'h1);

    // k25
    step();
    bus.irq_timer = 1'b0;
    chk_csr("tirq_mcause", 12'h342, 32'h8000_0007);
    chk_csr("unimpl_read", 12'h7C0, 32'h0);                      // retire -> 17

    // k26: mcycle low <= all ones (write beats increment)
    step();
    csr_write(12'hB00, 32'hFFFF_FFFF);                            // retire -> 18

    // k27
    step();
    chk_csr("mcycle_wr_lo", 12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycle_wr_hi", 12'hB80, 32'h0);                      // retire -> 19

    // k28: carry into high half; minstreth <= 5
    step();
    chk_csr("mcycle_carry_lo", 12'hB00, 32'h0);
    chk_csr("mcycle_carry_hi", 12'hC80, 32'h1);
    csr_write(12'hB82, 32'h5);                                    // low -> 20

    // k29: mepc low bits forced to 0
    step();
    chk_csr("minstret_lo", 12'hB02, 32'd20);
    chk_csr("minstret_hi", 12'hC82, 32'h5);
    csr_write(12'h341, 32'h303);

    // k30: WFI again (mie=0x880, no IRQ)
    step();
    chk_csr("mepc_align", 12'h341, 32'h300);
    bus.wfi_in = 1'b1;

    // k31: asleep, then reset pulse mid-cycle
    step();
    #1;
    check("sleep2_stall", 32'(bus.stall_out), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_stall_gated", 32'(bus.stall_out), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("after_rst_stall", 32'(bus.stall_out), 32'h0);
    chk_csr("after_rst_mtvec",  12'h305, MTVEC_INIT);
    chk_csr("after_rst_mcycle", 12'hB00, 32'h0);
    chk_csr("after_rst_mcyh",   12'hB80, 32'h0);
    chk_csr("after_rst_mepc",   12'h341, 32'h0);
    chk_csr("after_rst_mie",    12'h304, 32'h0);
    step();
    chk_csr("restart_mcycle", 12'hB00, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
